iot_tx: RTL and testbench
=========================

# iot_tx

Byte-serial transmitter for the IoT data-filter interface. Accepts 128-bit samples from a host-side write port, buffers them in a small FIFO, and streams each sample as 16 bytes, most-significant byte first, on the `in_en`/`iot_in` byte interface consumed by the data-filter receiver. It honours the receiver's `busy`. It also flags the end of every 8-sample round, so the host and the bench can align with the receiver's round boundaries.

## Interface
- `DEPTH`, default 4: FIFO entries (128-bit each), power of two, ≥2.
- `SAMPLES_PER_ROUND`, default 8: samples per round; `round_done` pulses after the last byte of each round.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `wr_en` input 1: push `wr_data` into FIFO this cycle.
- `wr_data` input 128: sample to transmit.
- `busy` input 1: receiver stall; while high no byte is issued.
- `full` output 1: FIFO holds `DEPTH` entries (combinational from count).
- `ovf` output 1: sticky; set when `wr_en`=1 while `full`=1; cleared only by `rst`.
- `in_en` output 1: registered byte strobe; names match the receiver port it drives.
- `iot_in` output 8: registered byte; valid only when `in_en`=1.
- `round_done` output 1: registered one-cycle pulse.
- `idle` output 1: FIFO empty and no sample in flight.

## Operation
- Reset values: `in_en`=0, `iot_in`=8'h00, `round_done`=0, `ovf`=0, `full`=0, `idle`=1. FIFO pointers, byte counter and sample counter are 0, and the FSM is in IDLE.
- FIFO: a write at `full` is dropped, and `ovf` is set. Write and pop in the same cycle are both honoured when not full. `full` is evaluated before the pop, so a write on the cycle a full FIFO pops is still dropped.
- FSM states:
  - IDLE: no sample loaded. If the FIFO is non-empty, pop the head into the 128-bit shift register, set byte counter `bc`=15 and go to SEND.
  - SEND: on each edge where `busy`=0, drive `iot_in`=`shreg[8*bc +: 8]` with `in_en`=1, then decrement `bc`. On an edge where `busy`=1, drive `in_en`=0 and hold `bc` and `shreg`.
  - SEND exit after the byte with `bc`=0:
    - FIFO non-empty: pop and reload in the same edge with `bc`=15 and stay in SEND. Back-to-back samples therefore have no gap.
    - FIFO empty: go to IDLE.
- Byte order: byte 15 (bits 127:120) is sent first and byte 0 last. This lets the receiver's shift-in reassemble the sample unchanged.
- Sample counter `sc` (0..`SAMPLES_PER_ROUND`-1) increments when byte 0 of a sample issues. When it wraps from the last value to 0, `round_done` pulses for one cycle, coincident with that final byte.
- Width rules: `bc` is 4 bits, `sc` is clog2(`SAMPLES_PER_ROUND`) bits, and the FIFO count is clog2(`DEPTH`)+1 bits. No arithmetic is applied to the data.

## Timing
- Latency: a `wr_en` sampled at edge E0 into an empty, idle block is popped at edge E1 (IDLE→SEND). The first byte appears with `in_en`=1 after edge E2. With no stalls, the 16 bytes occupy the cycles following E2..E17.
- Throughput: one byte per cycle while `busy`=0 and data is queued. A sample is 16 cycles, and a round is 128 cycles.
- `busy` is sampled at the clock edge. Assertion takes effect in the next output cycle (`in_en` falls after the edge that sees `busy`=1). No byte is skipped or repeated across a stall of any length.
- `busy`=1 in IDLE does not block the pop; it only stalls byte issue.
- Reset mid-sample: outputs go to reset values immediately (asynchronous). The partial sample and the FIFO contents are discarded, and `sc` returns to 0.
- `idle`=1 exactly when the FSM is in IDLE and the FIFO is empty.

## Structure
- Package `iot_pkg`:
  - `BYTES_PER_SAMPLE`=16.
  - Default `SAMPLES_PER_ROUND`=8.
  - `tx_state_t` enum {IDLE, SEND}.
  - Shared with the receiver-side testbench.
- Sub-module `iot_fifo`: synchronous FIFO, parameterised width and depth, with push, pop, full, empty and count.
- `iot_tx` holds the FSM, shift register, `bc`, `sc` and output registers.

## Test plan
- Single sample: write 128'h0102…0F10 once → after 2 cycles, `in_en` is high for 16 consecutive cycles with `iot_in`=01,02,…,10. Then `idle`=1, and `round_done` stays 0.
- Full round back-to-back: write 8 samples as fast as `full` allows → 128 consecutive `in_en` cycles with no gap. `round_done` pulses exactly once, on the 128th byte. The receiver model reassembles all 8 samples bit-exact.
- Stall: `busy`=1 for 5 cycles starting at byte 7 of sample 0x00112233…FF → `in_en`=0 for 5 cycles. Resume with byte 0x77 → byte sequence unchanged.
- Overflow: with `busy`=1 held, write `DEPTH`+2 samples → `full`=1 after `DEPTH` entries (plus one in flight) and `ovf`=1. Only the first `DEPTH`+1 samples are transmitted after `busy` drops.
- Reset mid-sample: assert `rst` after byte 9 of a sample with 2 samples queued → `in_en`=0 immediately and `idle`=1. `ovf`=0 and `sc`=0. A subsequent single write is transmitted cleanly from byte 15.

Source files
------------

// File: rtl/iot_pkg.sv
// iot_pkg: constants and types shared by the IoT byte transmitter
// and the receiver-side bench.
package iot_pkg;

  localparam int BYTES_PER_SAMPLE = 16;
  localparam int SAMPLE_W = 8 * BYTES_PER_SAMPLE;
  localparam int DEF_SAMPLES_PER_ROUND = 8;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

endpackage

// File: rtl/iot_tx_if.sv
// iot_tx_if: host write port plus byte-stream port of iot_tx.
// Ports: wr_en/wr_data/busy into the block; full/ovf/in_en/iot_in/
// round_done/idle out of it. slave = iot_tx side, master = driver side.
interface iot_tx_if;
  import iot_pkg::*;

  logic                wr_en;
  logic [SAMPLE_W-1:0] wr_data;
  logic                busy;
  logic                full;
  logic                ovf;
  logic                in_en;
  logic [7:0]          iot_in;
  logic                round_done;
  logic                idle;

  modport master (
    output wr_en, wr_data, busy,
    input  full, ovf, in_en, iot_in,
    input  round_done, idle
  );

  modport slave (
    input  wr_en, wr_data, busy,
    output full, ovf, in_en, iot_in,
    output round_done, idle
  );

endinterface

// File: rtl/iot_fifo.sv
// iot_fifo: synchronous FIFO, W bits wide, DEPTH (power of two) deep.
// Ports: clk, rst (async high), push/din, pop/dout (show-ahead head),
// full, empty, count. Push at full and pop at empty are ignored.
module iot_fifo #(
  parameter  int W     = 128,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  // full is taken from the pre-pop count, so a push on
  // the cycle a full FIFO pops is still dropped.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wp <= wp + AW'(1);
      end
      if (do_pop) begin
        rp <= rp + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iot_tx.sv
// iot_tx: buffers 128-bit samples and streams them MSB byte first on
// in_en/iot_in, honouring busy; round_done marks each round's last byte.
// Ports: clk, rst (async high), bus (iot_tx_if.slave).
module iot_tx
  import iot_pkg::*;
#(
  parameter int DEPTH             = 4,
  parameter int SAMPLES_PER_ROUND = DEF_SAMPLES_PER_ROUND
) (
  input logic     clk,
  input logic     rst,
  iot_tx_if.slave bus
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int SCW = (SAMPLES_PER_ROUND > 1) ?
                       $clog2(SAMPLES_PER_ROUND) : 1;
  localparam logic [SCW-1:0] SC_LAST =
    SCW'(SAMPLES_PER_ROUND - 1);

  tx_state_t           state;
  tx_state_t           state_d;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] shreg_d;
  logic [3:0]          bc;
  logic [3:0]          bc_d;
  logic [SCW-1:0]      sc;
  logic [SCW-1:0]      sc_d;
  logic                in_en_q;
  logic                in_en_d;
  logic [7:0]          iot_in_q;
  logic [7:0]          iot_in_d;
  logic                rd_q;
  logic                rd_d;
  logic                ovf_q;

  logic                pop;
  logic [SAMPLE_W-1:0] head;
  logic                full;
  logic                empty;
  logic [CW-1:0]       count;

  iot_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.wr_en),
    .din   (bus.wr_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bc_d     = bc;
    sc_d     = sc;
    in_en_d  = 1'b0;
    iot_in_d = iot_in_q;
    rd_d     = 1'b0;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        // busy does not gate the load, only byte issue.
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          bc_d    = 4'd15;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!bus.busy) begin
          in_en_d  = 1'b1;
          iot_in_d = shreg[{bc, 3'b000} +: 8];
          if (bc == 4'd0) begin
            rd_d = (sc == SC_LAST);
            sc_d = (sc == SC_LAST) ? '0 : sc + SCW'(1);
            // reload in the same edge: no gap between samples
            if (!empty) begin
              pop     = 1'b1;
              shreg_d = head;
              bc_d    = 4'd15;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bc_d = bc - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bc       <= '0;
      sc       <= '0;
      in_en_q  <= 1'b0;
      iot_in_q <= 8'h00;
      rd_q     <= 1'b0;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      bc       <= bc_d;
      sc       <= sc_d;
      in_en_q  <= in_en_d;
      iot_in_q <= iot_in_d;
      rd_q     <= rd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.full       = full;
  assign bus.ovf        = ovf_q;
  assign bus.in_en      = in_en_q;
  assign bus.iot_in     = iot_in_q;
  assign bus.round_done = rd_q;
  assign bus.idle       = (state == IDLE) && (count == '0);

endmodule

// File: tb/tb_iot_tx.sv
// tb_iot_tx: randomized and directed bench for iot_tx against a
// sample-queue reference model with a receiver-side reassembler.
module tb_iot_tx;
  import iot_pkg::*;

  localparam int DEPTH = 4;
  localparam int SPR   = 8;
  localparam int RB    = BYTES_PER_SAMPLE * SPR;

  logic clk = 1'b0;
  logic rst = 1'b1;

  iot_tx_if bus();

  iot_tx #(
    .DEPTH             (DEPTH),
    .SAMPLES_PER_ROUND (SPR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // reference model: accepted samples in order, bytes MSB first
  logic [127:0] exp_s[$];
  logic [127:0] cur;
  logic [127:0] acc;
  logic [127:0] d;
  int k, nb, rd_cnt, run, maxrun, stalls, nrx;
  logic busy_q = 1'b0;

  always @(posedge clk) busy_q <= bus.busy;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (busy_q) chk("busy_hold", bus.in_en, 0);
      if (bus.in_en) begin
        if (k == 0) begin
          if (exp_s.size() == 0) begin
            chk("extra_byte", 1, 0);
            cur = '0;
          end else begin
            cur = exp_s.pop_front();
          end
        end
        chk("byte", bus.iot_in, cur[8*(15-k) +: 8]);
        acc = {acc[119:0], bus.iot_in};
        nb++;
        chk("rdone", bus.round_done, (nb % RB) == 0);
        if (bus.round_done) rd_cnt++;
        run++;
        if (run > maxrun) maxrun = run;
        k++;
        if (k == 16) begin
          k = 0;
          chk("rx_sample", acc, cur);
          nrx++;
        end
      end else begin
        run = 0;
        chk("rdone_quiet", bus.round_done, 0);
        if (k != 0) stalls++;
      end
    end
  end

  task automatic clear_model();
    exp_s.delete();
    k = 0; nb = 0; rd_cnt = 0; run = 0;
    maxrun = 0; stalls = 0; nrx = 0;
    acc = '0; cur = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.busy = 1'b0;
    #1;
    chk("rst_in_en", bus.in_en, 0);
    chk("rst_iot_in", bus.iot_in, 8'h00);
    chk("rst_rdone", bus.round_done, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_idle", bus.idle, 1);
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr(input logic [127:0] v);
    bus.wr_en = 1'b1;
    bus.wr_data = v;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic wr_ok(input logic [127:0] v);
    int t = 0;
    while (bus.full && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 1000) chk("full_timeout", 1, 0);
    exp_s.push_back(v);
    wr(v);
  endtask

  task automatic drain(input int maxc);
    int t = 0;
    while ((exp_s.size() != 0 || k != 0 || !bus.idle)
           && t < maxc) begin
      @(posedge clk); #1; t++;
    end
    chk("drain", t < maxc, 1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int t;
    int sent;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.busy = 1'b0;
    clear_model();
    do_reset();

    // single sample and first-byte latency
    d = 128'h0102030405060708090a0b0c0d0e0f10;
    exp_s.push_back(d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    chk("lat_e0", bus.in_en, 0);
    @(posedge clk); #1;
    chk("lat_e1", bus.in_en, 0);
    @(posedge clk); #1;
    chk("lat_e2", bus.in_en, 1);
    chk("first_byte", bus.iot_in, 8'h01);
    drain(100);
    chk("single_rd", rd_cnt, 0);
    chk("single_run", maxrun, 16);
    chk("single_idle", bus.idle, 1);

    // full round back-to-back
    do_reset();
    for (int i = 0; i < SPR; i++) wr_ok(rnd128());
    drain(400);
    chk("round_rd", rd_cnt, 1);
    chk("round_run", maxrun, RB);
    chk("round_nrx", nrx, SPR);

    // five-cycle stall before byte 0x77
    do_reset();
    d = 128'h00112233445566778899aabbccddeeff;
    exp_s.push_back(d);
    wr(d);
    repeat (8) @(posedge clk);
    #1 bus.busy = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.busy = 1'b0;
    drain(100);
    chk("stall_cycles", stalls, 5);
    chk("stall_nrx", nrx, 1);

    // overflow while the stream is stalled
    do_reset();
    bus.busy = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      d = rnd128();
      if (i <= DEPTH) exp_s.push_back(d);
      wr(d);
    end
    chk("ovf_full", bus.full, 1);
    chk("ovf_set", bus.ovf, 1);
    bus.busy = 1'b0;
    drain(500);
    chk("ovf_nrx", nrx, DEPTH + 1);
    chk("ovf_sticky", bus.ovf, 1);

    // reset after byte 9 with two samples queued
    do_reset();
    for (int i = 0; i < 3; i++) wr_ok(rnd128());
    t = 0;
    while (k < 10 && t < 200) begin
      @(negedge clk); #1; t++;
    end
    chk("mid_wait", t < 200, 1);
    do_reset();
    d = rnd128();
    exp_s.push_back(d);
    wr(d);
    drain(100);
    chk("post_rst_nrx", nrx, 1);
    for (int i = 1; i < SPR; i++) wr_ok(rnd128());
    drain(400);
    chk("post_rst_rd", rd_cnt, 1);

    // randomized writes and busy
    do_reset();
    sent = 0;
    t = 0;
    while (sent < 3 * SPR && t < 5000) begin
      bus.busy = ($urandom_range(0, 3) == 0);
      if (!bus.full && $urandom_range(0, 1) == 1) begin
        d = rnd128();
        exp_s.push_back(d);
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        sent++;
      end else begin
        bus.wr_en = 1'b0;
      end
      @(posedge clk); #1; t++;
    end
    bus.wr_en = 1'b0;
    bus.busy = 1'b0;
    chk("rand_sent", sent, 3 * SPR);
    drain(2000);
    chk("rand_nrx", nrx, 3 * SPR);
    chk("rand_rd", rd_cnt, 3);
    chk("rand_ovf", bus.ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
